fifo_ctrl: RTL
==============

# fifo_ctrl

Synchronous FIFO controller that drives the FIFO's storage RAM from the user side. It accepts push/pop requests, maintains wrap-bit read/write pointers and the occupancy count, and generates the RAM's active-low write/read enables, write-qualify strobe and addresses. It captures the RAM's combinational read data into a registered output. The block sits between the FIFO's producer/consumer and the RAM instance in the FIFO top level.

## Interface
- DEPTH, 8, RAM address width in bits; the FIFO holds 2**DEPTH entries.
- WIDTH, 4, data width in bits.
- ALMOST_MARGIN, 1, occupancy margin for the almost_full/almost_empty thresholds.

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- push  in  1  write request; data on write_data_in.
- write_data_in  in  WIDTH  data to enqueue.
- pop  in  1  read request.
- data_out  out  WIDTH  registered dequeued word.
- data_out_valid  out  1  one-cycle pulse; data_out holds a new word.
- full, empty  out  1  registered occupancy flags.
- almost_full, almost_empty  out  1  registered threshold flags.
- count  out  DEPTH+1  registered occupancy, 0..2**DEPTH.
- overflow, underflow  out  1  one-cycle pulse on a rejected push or pop.
- ram_write_enable  out  1  active-low RAM write enable.
- ram_valid_write  out  1  RAM write qualifier, active-high.
- ram_write_address, ram_read_address  out  DEPTH  RAM addresses.
- ram_write_data  out  WIDTH  RAM write data.
- ram_read_enable  out  1  active-low RAM read enable.
- ram_read_data  in  WIDTH  RAM combinational read data; high-Z when ram_read_enable is high.

## Operation
- Pointers: wptr and rptr are DEPTH+1 bits (wrap bit plus address). The RAM addresses are the low DEPTH bits. Each pointer increments by 1 mod 2**(DEPTH+1) on an accepted operation.
- pop_ok = pop && !empty.
- push_ok = push && (!full || pop_ok). A simultaneous push and pop while full is allowed: the RAM read happens combinationally before the write commits at the edge.
- RAM write path:
  - ram_write_enable = !push_ok, ram_valid_write = push_ok.
  - ram_write_address = wptr[DEPTH-1:0]; ram_write_data = write_data_in.
  - Both are combinational, so the write lands at the same edge the push is accepted.
- RAM read path:
  - ram_read_enable = !pop_ok; ram_read_address = rptr[DEPTH-1:0].
  - On a pop_ok edge, data_out <= ram_read_data and data_out_valid <= 1. Otherwise data_out_valid <= 0 and data_out holds its value.
- Count update:
  - push_ok only: next_count = count+1.
  - pop_ok only: next_count = count-1.
  - both, or neither: next_count = count.
- Flags are registered from next_count:
  - empty = (next_count==0); full = (next_count==2**DEPTH).
  - almost_full = (next_count >= 2**DEPTH-ALMOST_MARGIN).
  - almost_empty = (next_count <= ALMOST_MARGIN).
- overflow <= push && !push_ok; underflow <= pop && !pop_ok. Both are single-cycle pulses, not sticky.
- A rejected request changes no pointer, no count and no RAM contents. The two RAM enables are never driven low on a rejected request.
- Pointer wrap: a full FIFO has equal address bits and differing wrap bits; an empty FIFO has equal wrap and address bits. Flag logic relies on count, and the pointer relation must agree with count at all times.

## Timing
- Reset values: wptr=0, rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (with ALMOST_MARGIN < 2**DEPTH), data_out=0, data_out_valid=0, overflow=0, underflow=0.
- During reset, push_ok and pop_ok are forced to 0, so ram_write_enable=1, ram_read_enable=1 and ram_valid_write=0.
- Reset asserted mid-operation discards all queued entries at that edge. RAM contents are left untouched and are don't-care.
- Write latency: the word is in the RAM at the push edge, and is readable by a pop in the next cycle.
- Read latency: data_out and data_out_valid are updated at the pop_ok edge, one cycle after the request.
- Flag latency: flags reflect the accepted operations of the preceding edge. No combinational path exists from push or pop to any flag.

## Structure
- Package fifo_pkg holds the default constants FIFO_DEPTH_BITS=8, FIFO_WIDTH=4 and FIFO_ALMOST_MARGIN=1, shared with the FIFO top and its bench.
- Sub-module fifo_ptr (parameter DEPTH; ports clock, reset, inc, ptr[DEPTH:0]) is a wrap-bit pointer counter. It is instantiated twice, once for wptr and once for rptr.
- The FIFO top instantiates fifo_ctrl and the RAM and connects their ports one-to-one.

## Test plan
All scenarios use DEPTH=3, WIDTH=4, ALMOST_MARGIN=1.
- Reset, then push 0x1..0x8 on consecutive cycles:
  - almost_full rises after the 7th edge; full=1 and count=8 after the 8th edge.
  - A 9th push gives overflow=1 for one cycle and count stays 8.
- From full, pop 8 times:
  - data_out_valid pulses carry 0x1..0x8 in order, each one cycle after its pop.
  - empty=1 after the last edge; a further pop gives underflow=1, and ram_read_enable stays high.
- Simultaneous push and pop:
  - With count=8, push 0xA with pop: data_out=0x1, count stays 8, full stays 1, no overflow.
  - With count=0, the same stimulus gives push accepted, pop rejected, underflow=1, count=1.
- Wrap-around: 20 cycles of alternating push/pop of an incrementing pattern with count kept at 3. Pointers cross 7→0 and the wrap bit toggles; data order is preserved and no flag glitches occur.
- Reset mid-stream at count=5: the next cycle shows empty=1, count=0, data_out_valid=0. The following push/pop returns the newly pushed value, not stale data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared default constants for the FIFO controller, the FIFO top and its bench.
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH_BITS    = 8;
    localparam int unsigned FIFO_WIDTH         = 4;
    localparam int unsigned FIFO_ALMOST_MARGIN = 1;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter: DEPTH address bits plus one wrap bit, rolls over naturally.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_BITS
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           inc,
    output logic [DEPTH:0] ptr
);

    localparam int unsigned PW = DEPTH + 1;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointer/count bookkeeping, RAM enables/addresses and
// registered capture of the RAM's combinational read data.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH         = FIFO_DEPTH_BITS,
    parameter int unsigned WIDTH         = FIFO_WIDTH,
    parameter int unsigned ALMOST_MARGIN = FIFO_ALMOST_MARGIN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] write_data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [DEPTH:0]   count,
    output logic             overflow,
    output logic             underflow,
    output logic             ram_write_enable,
    output logic             ram_valid_write,
    output logic [DEPTH-1:0] ram_write_address,
    output logic [WIDTH-1:0] ram_write_data,
    output logic             ram_read_enable,
    output logic [DEPTH-1:0] ram_read_address,
    input  logic [WIDTH-1:0] ram_read_data
);

    localparam int unsigned CW = DEPTH + 1;
    localparam logic [CW-1:0] CAPACITY = CW'(2 ** DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(2 ** DEPTH - ALMOST_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL = CW'(ALMOST_MARGIN);

    logic          push_ok;
    logic          pop_ok;
    logic [DEPTH:0] wptr;
    logic [DEPTH:0] rptr;
    logic [DEPTH:0] next_count;

    // A pop frees a slot in the same cycle, so push-while-full is legal alongside a pop.
    assign pop_ok  = !reset && pop && !empty;
    assign push_ok = !reset && push && (!full || pop_ok);

    fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clock (clock),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (wptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clock (clock),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (rptr)
    );

    assign ram_write_enable  = !push_ok;
    assign ram_valid_write   = push_ok;
    assign ram_write_address = wptr[DEPTH-1:0];
    assign ram_write_data    = write_data_in;
    assign ram_read_enable   = !pop_ok;
    assign ram_read_address  = rptr[DEPTH-1:0];

    always_comb begin
        next_count = count;
        if (push_ok && !pop_ok) begin
            next_count = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            next_count = count - CW'(1);
        end
    end

    // Flags are registered from next_count so no push/pop path reaches them combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            empty          <= 1'b1;
            almost_empty   <= 1'b1;
            full           <= 1'b0;
            almost_full    <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            count          <= next_count;
            empty          <= (next_count == '0);
            full           <= (next_count == CAPACITY);
            almost_full    <= (next_count >= AF_LEVEL);
            almost_empty   <= (next_count <= AE_LEVEL);
            data_out_valid <= pop_ok;
            overflow       <= push && !push_ok;
            underflow      <= pop && !pop_ok;
            if (pop_ok) begin
                data_out <= ram_read_data;
            end
        end
    end

    // Pointer distance must always equal the occupancy count (wrap bit disambiguates full).
    ptr_count_agree: assert property (@(posedge clock) disable iff (reset)
        (CW'(wptr - rptr) == count));

endmodule
